// File: rtl/pid_pkg.sv
// Shared types and widths for the incremental PID duty compensator.
// FSM encoding plus datapath widths used by the top and the clamp.
package pid_pkg;

  localparam int ERR_W  = 9;
  localparam int ACC_W  = 24;
  localparam int COEF_W = 12;
  localparam int PROD_W = ERR_W + COEF_W;
  localparam int DUTY_W = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC_A,
    S_MAC_B,
    S_MAC_C,
    S_SAT
  } state_e;

endpackage

// File: rtl/pid_sat.sv
// Duty clamp: limits a signed controller output to [DMIN, DMAX].
// sat_o tells the caller the output was limited (drives anti-windup).
module pid_sat
  import pid_pkg::*;
#(
  parameter int DMIN = 0,
  parameter int DMAX = 1000
) (
  input  logic signed [ACC_W-1:0]  y_i,
  output logic        [DUTY_W-1:0] duty_o,
  output logic                     sat_o
);

  localparam logic signed [ACC_W-1:0] LO = ACC_W'(DMIN);
  localparam logic signed [ACC_W-1:0] HI = ACC_W'(DMAX);

  always_comb begin
    duty_o = y_i[DUTY_W-1:0];
    sat_o  = 1'b0;
    if (y_i < LO) begin
      duty_o = DUTY_W'(DMIN);
      sat_o  = 1'b1;
    end else if (y_i > HI) begin
      duty_o = DUTY_W'(DMAX);
      sat_o  = 1'b1;
    end
  end

endmodule

// File: rtl/pid_duty_comp.sv
// Incremental PID duty compensator, one MAC per clock, five-cycle
// sample period; clamped duty with anti-windup on the running sum.
module pid_duty_comp
  import pid_pkg::*;
#(
  parameter logic signed [COEF_W-1:0] COEF_A = 12'sd64,
  parameter logic signed [COEF_W-1:0] COEF_B = 12'sd0,
  parameter logic signed [COEF_W-1:0] COEF_C = 12'sd0,
  parameter int SHIFT     = 6,
  parameter int DMIN      = 0,
  parameter int DMAX      = 1000,
  parameter int DUTY_INIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  vref,
  input  logic [7:0]  adc_in,
  input  logic        adc_valid,
  output logic [9:0]  duty_cmd,
  output logic        duty_valid,
  output logic        busy,
  output logic        overrun
);

  localparam logic signed [ACC_W-1:0] DPREV_RST =
    ACC_W'(DUTY_INIT) <<< SHIFT;

  state_e state_q, state_d;

  logic signed [ERR_W-1:0]  e0_q, e0_d, e1_q, e1_d, e2_q, e2_d;
  logic signed [ERR_W-1:0]  e_new, err;
  logic signed [COEF_W-1:0] coef;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_q, acc_d, dprev_q, dprev_d, y;
  logic        [DUTY_W-1:0] duty_q, duty_d, sat_duty;
  logic                     dv_q, dv_d, ovr_q, ovr_d, sat;

  assign e_new = $signed({1'b0, vref}) - $signed({1'b0, adc_in});
  assign y     = acc_q >>> SHIFT;

  // One shared multiplier; operands follow the MAC state.
  always_comb begin
    coef = COEF_A;
    err  = e0_q;
    unique case (state_q)
      S_MAC_B: begin
        coef = COEF_B;
        err  = e1_q;
      end
      S_MAC_C: begin
        coef = COEF_C;
        err  = e2_q;
      end
      default: ;
    endcase
    prod = coef * err;
  end

  pid_sat #(
    .DMIN (DMIN),
    .DMAX (DMAX)
  ) u_sat (
    .y_i    (y),
    .duty_o (sat_duty),
    .sat_o  (sat)
  );

  always_comb begin
    state_d = state_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    e2_d    = e2_q;
    acc_d   = acc_q;
    dprev_d = dprev_q;
    duty_d  = duty_q;
    dv_d    = 1'b0;
    ovr_d   = ovr_q | (adc_valid & (state_q != S_IDLE));
    unique case (state_q)
      S_IDLE: begin
        if (adc_valid) begin
          e0_d    = e_new;
          state_d = S_MAC_A;
        end
      end
      S_MAC_A: begin
        acc_d   = dprev_q + ACC_W'(prod);
        state_d = S_MAC_B;
      end
      S_MAC_B: begin
        acc_d   = acc_q + ACC_W'(prod);
        state_d = S_MAC_C;
      end
      S_MAC_C: begin
        acc_d   = acc_q + ACC_W'(prod);
        state_d = S_SAT;
      end
      S_SAT: begin
        duty_d  = sat_duty;
        dv_d    = 1'b1;
        // Re-seat the sum at the clamp so recovery is immediate.
        dprev_d = sat ? (ACC_W'(sat_duty) <<< SHIFT) : acc_q;
        e2_d    = e1_q;
        e1_d    = e0_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      e0_q    <= '0;
      e1_q    <= '0;
      e2_q    <= '0;
      acc_q   <= '0;
      dprev_q <= DPREV_RST;
      duty_q  <= DUTY_W'(DUTY_INIT);
      dv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      e2_q    <= e2_d;
      acc_q   <= acc_d;
      dprev_q <= dprev_d;
      duty_q  <= duty_d;
      dv_q    <= dv_d;
      ovr_q   <= ovr_d;
    end
  end

  assign duty_cmd   = duty_q;
  assign duty_valid = dv_q;
  assign busy       = (state_q != S_IDLE);
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_pid_duty_comp.sv
// Directed bench for pid_duty_comp: default-gain instance plus a
// PI-style instance (A=96, B=-64) for history and mid-run reset.
module tb_pid_duty_comp;

  logic       clk = 1'b0;
  logic       rst1, rst2;
  logic [7:0] vref1, adc1, vref2, adc2;
  logic       av1, av2;
  logic [9:0] d1, d2;
  logic       dv1, dv2, b1, b2, o1, o2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pid_duty_comp u_dut1 (
    .clk        (clk),
    .rst        (rst1),
    .vref       (vref1),
    .adc_in     (adc1),
    .adc_valid  (av1),
    .duty_cmd   (d1),
    .duty_valid (dv1),
    .busy       (b1),
    .overrun    (o1)
  );

  pid_duty_comp #(
    .COEF_A (12'sd96),
    .COEF_B (-12'sd64),
    .SHIFT  (6)
  ) u_dut2 (
    .clk        (clk),
    .rst        (rst2),
    .vref       (vref2),
    .adc_in     (adc2),
    .adc_valid  (av2),
    .duty_cmd   (d2),
    .duty_valid (dv2),
    .busy       (b2),
    .overrun    (o2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic [7:0] v,
                       input logic [7:0] a, input logic val);
    if (sel == 1) begin
      vref1 = v; adc1 = a; av1 = val;
    end else begin
      vref2 = v; adc2 = a; av2 = val;
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one sample, wait (bounded) for duty_valid, check
  // latency and result. Leaves the DUT in IDLE with duty_valid high.
  task automatic sample(input int sel, input logic [7:0] v,
                        input logic [7:0] a, input int exp_duty,
                        input string tag);
    int lat;
    drive(sel, v, a, 1'b1);
    step();
    drive(sel, v, a, 1'b0);
    lat = 0;
    while (!((sel == 1) ? dv1 : dv2) && lat < 10) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_duty"}, int'((sel == 1) ? d1 : d2), exp_duty);
  endtask

  task automatic do_reset(input int sel);
    if (sel == 1) rst1 = 1'b0; else rst2 = 1'b0;
    step();
    step();
    if (sel == 1) rst1 = 1'b1; else rst2 = 1'b1;
  endtask

  initial begin
    int bc, pc;
    rst1 = 1'b0; rst2 = 1'b0;
    drive(1, 8'd0, 8'd0, 1'b0);
    drive(2, 8'd0, 8'd0, 1'b0);
    step();
    step();
    chk("rst_duty1", int'(d1), 0);
    chk("rst_dv1", int'(dv1), 0);
    chk("rst_busy1", int'(b1), 0);
    chk("rst_ovr1", int'(o1), 0);
    chk("rst_duty2", int'(d2), 0);
    rst1 = 1'b1; rst2 = 1'b1;

    // e=10, gain 1.0: 10 then 20; back-to-back with duty_valid
    sample(1, 8'd128, 8'd118, 10, "pi_s1");
    chk("pi_busy_at_dv", int'(b1), 0);
    sample(1, 8'd128, 8'd118, 20, "pi_s2");
    step();
    chk("dv_one_cycle", int'(dv1), 0);
    chk("duty_hold", int'(d1), 20);

    // Upper clamp and windup recovery
    do_reset(1);
    sample(1, 8'd255, 8'd0, 255, "up1");
    sample(1, 8'd255, 8'd0, 510, "up2");
    sample(1, 8'd255, 8'd0, 765, "up3");
    sample(1, 8'd255, 8'd0, 1000, "up4");
    sample(1, 8'd255, 8'd0, 1000, "up5");
    sample(1, 8'd118, 8'd128, 990, "unwind");

    // Lower clamp
    do_reset(1);
    sample(1, 8'd0, 8'd200, 0, "lo");
    sample(1, 8'd0, 8'd200, 0, "lo2");
    sample(1, 8'd10, 8'd0, 10, "lo_rec");

    // Three-cycle strobe: one result, overrun set, 4 busy cycles
    do_reset(1);
    chk("ovr_clear", int'(o1), 0);
    bc = 0;
    pc = 0;
    drive(1, 8'd128, 8'd118, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      if (b1) bc++;
      if (dv1) pc++;
    end
    drive(1, 8'd128, 8'd118, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      if (b1) bc++;
      if (dv1) pc++;
    end
    chk("ovr_pulses", pc, 1);
    chk("ovr_busy", bc, 4);
    chk("ovr_flag", int'(o1), 1);
    chk("ovr_duty", int'(d1), 10);
    sample(1, 8'd128, 8'd118, 20, "ovr_next");
    chk("ovr_sticky", int'(o1), 1);

    // A=96, B=-64: e=20,20 -> 30, 40
    sample(2, 8'd20, 8'd0, 30, "ab1");
    sample(2, 8'd20, 8'd0, 40, "ab2");
    step();

    // Reset while in MAC_B: aborted, history and dprev cleared
    drive(2, 8'd20, 8'd0, 1'b1);
    step();
    drive(2, 8'd20, 8'd0, 1'b0);
    step();
    rst2 = 1'b0;
    pc = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (dv2) pc++;
    end
    rst2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (dv2) pc++;
    end
    chk("mid_rst_nopulse", pc, 0);
    chk("mid_rst_duty", int'(d2), 0);
    chk("mid_rst_busy", int'(b2), 0);
    sample(2, 8'd20, 8'd0, 30, "mid_rst_next");
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
